// File: rtl/prog_loader.sv
// prog_loader: boot loader streaming a length-prefixed, XOR-checked image into imem, holding the core in reset until verified
module prog_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CSUM, RUN, ERR} state_t;
  localparam logic [16:0] DEPTH = 17'(2**ADDR_W);
  state_t              state, nxt;
  logic [15:0]         count;
  logic [1:0]          byte_idx;
  logic [DATA_W-9:0]   word_buf;
  logic [ADDR_W-1:0]   word_idx;
  logic [7:0]          csum;
  logic                acc;
  logic [15:0]         len;
  logic                last_word;
  assign acc       = rx_valid & rx_ready;
  assign len       = {rx_data, count[7:0]};
  assign last_word = 16'(word_idx) == count - 16'd1;
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= LEN_LO;
    else        state <= nxt;
  // next-state: a byte only moves the FSM when it is actually accepted
  always_comb begin
    nxt = state;
    case (state)
      LEN_LO: nxt = acc ? LEN_HI : state;
      LEN_HI: nxt = !acc ? state : len == 16'd0 ? CSUM : {1'b0, len} > DEPTH ? ERR : DATA;
      DATA:   nxt = acc && byte_idx == 2'd3 && last_word ? CSUM : state;
      CSUM:   nxt = !acc ? state : rx_data == csum ? RUN : ERR;
      default: nxt = state;
    endcase
  end
  // datapath and registered outputs; status flags follow the next state so they appear the cycle after the deciding byte
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
      count      <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      word_idx   <= '0;
      csum       <= '0;
    end else begin
      imem_we   <= 1'b0;
      rx_ready  <= nxt inside {LEN_LO, LEN_HI, DATA, CSUM};
      done      <= nxt == RUN;
      error     <= nxt == ERR;
      cpu_reset <= nxt != RUN;
      if (acc)
        case (state)
          LEN_LO: count[7:0]  <= rx_data;
          LEN_HI: count[15:8] <= rx_data;
          DATA: begin
            csum     <= csum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= word_idx;
              imem_wdata <= {rx_data, word_buf};
              word_idx   <= word_idx + 1'b1;
            end else
              word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
          end
          default: ;
        endcase
    end
endmodule
